// File: rtl/proc_pkg.sv
// Shared encodings for the 8-bit basic processor: sequencer states, opcodes, instruction fields.
// Combinational helpers only; no latency and no flow control.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_DECODE   = 3'd3,
        ST_IMM      = 3'd4,
        ST_IMM_LOAD = 3'd5,
        ST_EXEC     = 3'd6,
        ST_HALT     = 3'd7
    } state_e;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RSV_BIT = 3;
    localparam int DST_MSB = 2;
    localparam int DST_LSB = 0;

    function automatic logic [3:0] opcode_of(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] dst_of(input logic [7:0] instr);
        return instr[DST_MSB:DST_LSB];
    endfunction

endpackage

// File: rtl/instr_seq_exec_timer.sv
// Loadable down-counter; done is high while the count sits at zero (decoded from the flop).
// One cycle from load to the loaded value appearing; no backpressure.
module exec_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/instr_seq.sv
// Fetch/decode/execute sequencer: 3+EXEC_CYCLES cycles per single-byte op, 5+EXEC_CYCLES for MVI.
// No backpressure: memory answers one cycle after mem_rd, start is ignored while busy.
module instr_seq #(
    parameter int         EXEC_CYCLES = 3,
    parameter logic [3:0] OP_MVI      = proc_pkg::OP_MVI,
    parameter logic [3:0] OP_HLT      = proc_pkg::OP_HLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    output logic [3:0] ctr1,
    output logic       exec_strobe,
    output logic       busy,
    output logic       wr_en,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       halted
);
    import proc_pkg::*;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] imm_q, imm_d;
    logic       mem_rd_q, mem_rd_d;
    logic [3:0] ctr1_q, ctr1_d;
    logic       exec_strobe_q, exec_strobe_d;
    logic       wr_en_q, wr_en_d;
    logic       go_exec;
    logic       timer_done;
    logic       rsv_unused;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        imm_d         = imm_q;
        mem_rd_d      = 1'b0;
        ctr1_d        = OP_NOP;
        exec_strobe_d = 1'b0;
        wr_en_d       = 1'b0;
        go_exec       = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = 8'd0;
                    mem_rd_d = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = mem_data;
                pc_d    = pc_q + 8'd1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode_of(ir_q) == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (opcode_of(ir_q) == OP_MVI) begin
                    state_d  = ST_IMM;
                    mem_rd_d = 1'b1;
                end else begin
                    go_exec = 1'b1;
                end
            end
            ST_IMM: state_d = ST_IMM_LOAD;
            ST_IMM_LOAD: begin
                imm_d   = mem_data;
                pc_d    = pc_q + 8'd1;
                go_exec = 1'b1;
            end
            ST_EXEC: begin
                if (timer_done) begin
                    state_d  = ST_FETCH;
                    mem_rd_d = 1'b1;
                end else begin
                    ctr1_d = opcode_of(ir_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so the first EXEC cycle's values are set on entry.
        if (go_exec) begin
            state_d       = ST_EXEC;
            ctr1_d        = opcode_of(ir_q);
            exec_strobe_d = 1'b1;
            wr_en_d       = (opcode_of(ir_q) == OP_MVI);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= 8'd0;
            ir_q          <= 8'd0;
            imm_q         <= 8'd0;
            mem_rd_q      <= 1'b0;
            ctr1_q        <= OP_NOP;
            exec_strobe_q <= 1'b0;
            wr_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            imm_q         <= imm_d;
            mem_rd_q      <= mem_rd_d;
            ctr1_q        <= ctr1_d;
            exec_strobe_q <= exec_strobe_d;
            wr_en_q       <= wr_en_d;
        end
    end

    exec_timer u_exec_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (go_exec),
        .load_val (EXEC_LAST),
        .en       (state_q == ST_EXEC),
        .done     (timer_done)
    );

    assign rsv_unused  = ir_q[RSV_BIT];
    assign mem_addr    = pc_q;
    assign mem_rd      = mem_rd_q;
    assign ctr1        = ctr1_q;
    assign exec_strobe = exec_strobe_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = dst_of(ir_q);
    assign wr_data     = imm_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Fetch/decode/execute sequencer for the 8-bit basic processor.
- Reads instruction bytes from a synchronous program memory and decodes them.
- Presents the 4-bit opcode (ctr1) to the execution units, including the move-immediate unit, and holds each instruction for a fixed number of execute cycles.
- Drives the register-file write port directly for move-immediate (MVI) instructions.

Parameters:
- EXEC_CYCLES, 3: cycles each instruction spends in EXEC; legal range 1..15.
- OP_MVI, 4'b1100: move-immediate opcode; two-byte instruction.
- OP_HLT, 4'b1111: halt opcode.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins execution at pc=0 from IDLE or HALT
- mem_addr  output  8  program memory address; equals pc
- mem_rd  output  1  memory read strobe; data valid on mem_data the next cycle
- mem_data  input  8  program memory read data
- ctr1  output  4  opcode to execution units; 4'b0000 outside EXEC
- exec_strobe  output  1  high on the first EXEC cycle only
- busy  output  1  high in every state except IDLE and HALT
- wr_en  output  1  register write enable (MVI only)
- wr_addr  output  3  destination register
- wr_data  output  8  immediate value
- halted  output  1  high in HALT

Behaviour:
- Instruction byte format:
  - [7:4] opcode.
  - [3] reserved, ignored.
  - [2:0] destination register.
  - MVI is followed by one immediate byte.
- Reset (asynchronous, any state):
  - State = IDLE; pc, ir, imm and the exec counter = 0.
  - All outputs = 0.
  - Reset asserted mid-instruction aborts it: no wr_en is issued.
- States and transitions:
  - IDLE: start -> FETCH with pc=0; otherwise stay.
  - FETCH: mem_rd=1, mem_addr=pc -> LOAD.
  - LOAD: ir<=mem_data, pc<=pc+1 -> DECODE.
  - DECODE:
    - opcode==OP_HLT -> HALT.
    - opcode==OP_MVI -> IMM.
    - otherwise -> EXEC.
  - IMM: mem_rd=1, mem_addr=pc -> IMM_LOAD.
  - IMM_LOAD: imm<=mem_data, pc<=pc+1 -> EXEC.
  - EXEC:
    - ctr1=ir[7:4] for exactly EXEC_CYCLES cycles; exec counter counts 0..EXEC_CYCLES-1.
    - At the last count -> FETCH.
    - exec_strobe on count 0 only.
    - If MVI: wr_en=1 on count 0 with wr_addr=ir[2:0] and wr_data=imm; wr_en=0 on later counts.
  - HALT: halted=1, pc frozen. start -> FETCH with pc=0, halted drops the same edge.
- Latency:
  - Single-byte instruction: 3+EXEC_CYCLES cycles from FETCH entry to the next FETCH (6 at default).
  - MVI: 5+EXEC_CYCLES cycles (8 at default).
  - HLT: halted high 3 cycles after FETCH entry.
- Boundary conditions:
  - pc is 8-bit and wraps 255->0. An MVI at address 255 takes its immediate from address 0.
  - start while busy: ignored.
  - start coincident with rst: rst wins.
- Output timing: outputs are registered or decoded purely from the registered state; there is no combinational path from mem_data to any output.

Decomposition:
- Shared package proc_pkg holds:
  - state encoding: IDLE, FETCH, LOAD, DECODE, IMM, IMM_LOAD, EXEC, HALT;
  - opcode constants OP_MVI, OP_HLT, OP_NOP (4'b0000);
  - field position constants.
- One natural sub-module: exec_timer. It is a loadable down-counter with a done flag, used for the EXEC hold; everything else stays in instr_seq.

Test Plan:
- Reset state: assert rst mid-run -> all outputs 0 immediately (asynchronous); after release, state stays IDLE until start.
- Basic MVI: mem[0]=0xC2, mem[1]=0x5A, mem[2]=0xF0; pulse start -> wr_en one cycle with wr_addr=2, wr_data=0x5A. On that same cycle ctr1=4'b1100 and exec_strobe=1. ctr1 holds 4'b1100 for 3 cycles, then halted=1 with pc=3.
- NOP timing: mem[0]=0x00, mem[1]=0x00, mem[2]=0xF0 -> FETCH entries 6 cycles apart. wr_en never asserted. halted 15 cycles after the start pulse registers.
- pc wrap: force pc=255 with mem[255]=0xC7, mem[0]=0x11 -> wr_addr=7, wr_data=0x11, next fetch at pc=1.
- Restart: start during EXEC -> no effect. start in HALT -> fetch from address 0 and the program re-executes identically.
- EXEC_CYCLES=1 build: MVI then HLT -> ctr1 nonzero for exactly 1 cycle; instruction period 6 cycles.
